// File: rtl/yon_denetleyici.sv
// Obstacle-avoiding robot direction controller: debounces the three raw obstacle
// sensors, registers the direction code and runs the timed turn/reverse FSM.
module yon_denetleyici #(
    parameter int SUZGEC_N  = 4,
    parameter int DONUS_CYC = 8,
    parameter int GERI_CYC  = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       calis,
    input  logic       sag,
    input  logic       sol,
    input  logic       on,
    output logic [1:0] yon,
    output logic       motor_sol,
    output logic       motor_sag,
    output logic       geri,
    output logic       mesgul
);

    localparam int FW   = $clog2(SUZGEC_N) + 1;
    localparam int TMAX = (DONUS_CYC > GERI_CYC) ? DONUS_CYC : GERI_CYC;
    localparam int TW   = $clog2(TMAX) + 1;

    localparam logic [FW-1:0] FLT_SON  = FW'(SUZGEC_N - 1);
    localparam logic [FW-1:0] FLT_BIR  = FW'(1);
    localparam logic [TW-1:0] DON_YUK  = TW'(DONUS_CYC - 1);
    localparam logic [TW-1:0] GERI_YUK = TW'(GERI_CYC - 1);
    localparam logic [TW-1:0] ZMN_BIR  = TW'(1);

    typedef enum logic [2:0] {
        BEKLE    = 3'd0,
        ILERI    = 3'd1,
        SOLA_DON = 3'd2,
        SAGA_DON = 3'd3,
        GERI     = 3'd4
    } durum_t;

    // ------------------------------------------------------------------
    // Sensor debounce: bit 0 = sag, bit 1 = sol, bit 2 = on
    // ------------------------------------------------------------------
    logic [2:0] ham;
    logic [2:0] suz;

    assign ham = {on, sol, sag};

    for (genvar i = 0; i < 3; i++) begin : g_suzgec
        logic [FW-1:0] sayac_q, sayac_d;
        logic          filt_q, filt_d;

        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        always_comb begin
            filt_d  = filt_q;
            sayac_d = '0;
            if (ham[i] != filt_q) begin
                if (sayac_q == FLT_SON) begin
                    filt_d = ham[i];
                end else begin
                    sayac_d = sayac_q + FLT_BIR;
                end
            end
        end

        // NOTE: state is updated with non-blocking assignments so every flop
        // samples the pre-edge values regardless of block ordering.
        always_ff @(posedge clk) begin
            if (rst) begin
                sayac_q <= '0;
                filt_q  <= 1'b0;
            end else begin
                sayac_q <= sayac_d;
                filt_q  <= filt_d;
            end
        end

        assign suz[i] = filt_q;
    end

    // ------------------------------------------------------------------
    // Direction code from the filtered bits: {yon_solbit, yon_sagbit}
    // ------------------------------------------------------------------
    logic [1:0] kod;
    logic [1:0] yon_q, yon_d;

    always_comb begin
        kod[1] = suz[2] | (suz[1] & ~suz[0]);
        kod[0] = suz[2] | suz[0];
        yon_d  = kod;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            yon_q <= 2'b00;
        end else begin
            yon_q <= yon_d;
        end
    end

    assign yon = yon_q;

    // ------------------------------------------------------------------
    // Manoeuvre state machine
    // ------------------------------------------------------------------
    durum_t        durum_q, durum_d;
    logic [TW-1:0] zaman_q, zaman_d;

    always_comb begin
        durum_d = durum_q;
        zaman_d = zaman_q;

        if (!calis) begin
            durum_d = BEKLE;
            zaman_d = '0;
        end else begin
            unique case (durum_q)
                BEKLE: begin
                    durum_d = ILERI;
                end

                // Decides from the live filtered bits, not the registered yon.
                ILERI: begin
                    unique case (kod)
                        2'b01: begin
                            durum_d = SOLA_DON;
                            zaman_d = DON_YUK;
                        end
                        2'b10: begin
                            durum_d = SAGA_DON;
                            zaman_d = DON_YUK;
                        end
                        2'b11: begin
                            durum_d = GERI;
                            zaman_d = GERI_YUK;
                        end
                        default: begin
                            durum_d = ILERI;
                        end
                    endcase
                end

                SOLA_DON, SAGA_DON: begin
                    if (zaman_q == '0) begin
                        durum_d = ILERI;
                    end else begin
                        zaman_d = zaman_q - ZMN_BIR;
                    end
                end

                // After backing up, always escape with a left turn.
                GERI: begin
                    if (zaman_q == '0) begin
                        durum_d = SOLA_DON;
                        zaman_d = DON_YUK;
                    end else begin
                        zaman_d = zaman_q - ZMN_BIR;
                    end
                end

                default: begin
                    durum_d = BEKLE;
                    zaman_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            durum_q <= BEKLE;
            zaman_q <= '0;
        end else begin
            durum_q <= durum_d;
            zaman_q <= zaman_d;
        end
    end

    // ------------------------------------------------------------------
    // Moore output decode
    // ------------------------------------------------------------------
    always_comb begin
        motor_sol = 1'b0;
        motor_sag = 1'b0;
        geri      = 1'b0;
        mesgul    = 1'b0;
        unique case (durum_q)
            ILERI: begin
                motor_sol = 1'b1;
                motor_sag = 1'b1;
            end
            SOLA_DON: begin
                motor_sag = 1'b1;
                mesgul    = 1'b1;
            end
            SAGA_DON: begin
                motor_sol = 1'b1;
                mesgul    = 1'b1;
            end
            GERI: begin
                motor_sol = 1'b1;
                motor_sag = 1'b1;
                geri      = 1'b1;
                mesgul    = 1'b1;
            end
            default: begin
                motor_sol = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_yon_denetleyici.sv
// Self-checking bench for yon_denetleyici: directed scenarios plus randomized
// sensor traffic, all compared against a queue-based manoeuvre plan model.
module tb_yon_denetleyici;

    localparam int N  = 4;
    localparam int DC = 8;
    localparam int GC = 6;

    logic       clk = 1'b0;
    logic       rst;
    logic       calis;
    logic       sag;
    logic       sol;
    logic       on;
    logic [1:0] yon;
    logic       motor_sol;
    logic       motor_sag;
    logic       geri;
    logic       mesgul;

    int checks = 0;
    int errors = 0;

    yon_denetleyici #(
        .SUZGEC_N (N),
        .DONUS_CYC(DC),
        .GERI_CYC (GC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .calis    (calis),
        .sag      (sag),
        .sol      (sol),
        .on       (on),
        .yon      (yon),
        .motor_sol(motor_sol),
        .motor_sag(motor_sag),
        .geri     (geri),
        .mesgul   (mesgul)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model. Filter: a sensor flips after N consecutive
    // disagreeing samples. Manoeuvres: a queue holding the expected
    // {motor_sol, motor_sag, geri, mesgul} for every remaining cycle.
    // ------------------------------------------------------------------
    int         run_m[3];
    bit         f_m[3];
    logic [1:0] yon_m;
    bit         idle_m = 1'b1;
    logic [3:0] plan[$];

    function automatic logic [1:0] decide(bit fs, bit fl, bit fo);
        if (fo)      return 2'b11;
        else if (fs) return 2'b01;
        else if (fl) return 2'b10;
        else         return 2'b00;
    endfunction

    function automatic logic [5:0] expected();
        logic [3:0] m;
        if (idle_m)              m = 4'b0000;
        else if (plan.size() > 0) m = plan[0];
        else                     m = 4'b1100;
        return {yon_m, m};
    endfunction

    task automatic model_edge();
        bit         raw[3];
        logic [1:0] d;
        raw[0] = sag;
        raw[1] = sol;
        raw[2] = on;
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                run_m[i] = 0;
                f_m[i]   = 1'b0;
            end
            yon_m  = 2'b00;
            idle_m = 1'b1;
            plan.delete();
        end else begin
            d     = decide(f_m[0], f_m[1], f_m[2]);
            yon_m = d;
            if (!calis) begin
                idle_m = 1'b1;
                plan.delete();
            end else if (idle_m) begin
                idle_m = 1'b0;
            end else if (plan.size() > 0) begin
                void'(plan.pop_front());
            end else if (d == 2'b01) begin
                repeat (DC) plan.push_back(4'b0101);
            end else if (d == 2'b10) begin
                repeat (DC) plan.push_back(4'b1001);
            end else if (d == 2'b11) begin
                repeat (GC) plan.push_back(4'b1111);
                repeat (DC) plan.push_back(4'b0101);
            end
            for (int i = 0; i < 3; i++) begin
                if (raw[i] != f_m[i]) begin
                    run_m[i]++;
                    if (run_m[i] == N) begin
                        f_m[i]   = raw[i];
                        run_m[i] = 0;
                    end
                end else begin
                    run_m[i] = 0;
                end
            end
        end
    endtask

    // One clock: model follows the edge, outputs compared on the falling edge.
    task automatic tick(input string tag);
        logic [5:0] exp_v;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        exp_v = expected();
        checks++;
        if ({yon, motor_sol, motor_sag, geri, mesgul} !== exp_v) begin
            errors++;
            $display("FAIL %s model t=%0t: got yon,sol,sag,geri,mesgul=%b required %b", tag, $time,
                     {yon, motor_sol, motor_sag, geri, mesgul}, exp_v);
        end
        checks++;
        if (geri === 1'b1 && motor_sol !== motor_sag) begin
            errors++;
            $display("FAIL %s geri_one_wheel: got sol=%b sag=%b required equal", tag, motor_sol, motor_sag);
        end
    endtask

    task automatic do_reset(input logic run);
        rst   = 1'b1;
        calis = run;
        sag   = 1'b0;
        sol   = 1'b0;
        on    = 1'b0;
        tick("reset");
        rst = 1'b0;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        rst   = 1'b1;
        calis = 1'b0;
        sag   = 1'b1;
        sol   = 1'b1;
        on    = 1'b1;
        tick("rst_hold");
        tick("rst_hold");
        checks++;
        if ({yon, motor_sol, motor_sag, geri, mesgul} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b required 000000", {yon, motor_sol, motor_sag, geri, mesgul});
        end
        rst = 1'b0;
        repeat (10) tick("settle");
        checks++;
        if (yon !== 2'b11) begin
            errors++;
            $display("FAIL settle_yon: got %b required 11", yon);
        end
        checks++;
        if ({motor_sol, motor_sag, geri, mesgul} !== 4'b0000) begin
            errors++;
            $display("FAIL settle_idle: got %b required 0000", {motor_sol, motor_sag, geri, mesgul});
        end
    endtask

    task automatic test_sag_turn();
        int cnt;
        do_reset(1'b1);
        repeat (3) tick("fwd");
        sag = 1'b1;
        repeat (N) tick("sag_fill");
        checks++;
        if ({motor_sol, motor_sag, mesgul} !== 3'b110) begin
            errors++;
            $display("FAIL sag_before_turn: got %b required 110", {motor_sol, motor_sag, mesgul});
        end
        tick("sag_e5");
        checks++;
        if ({motor_sol, motor_sag, geri, mesgul} !== 4'b0101) begin
            errors++;
            $display("FAIL sag_turn_start: got %b required 0101", {motor_sol, motor_sag, geri, mesgul});
        end
        sag = 1'b0;
        cnt = 1;
        while (mesgul === 1'b1 && cnt < 40) begin
            tick("sag_turn");
            if (mesgul === 1'b1) cnt++;
        end
        checks++;
        if (cnt != DC) begin
            errors++;
            $display("FAIL sag_turn_len: got %0d required %0d", cnt, DC);
        end
        checks++;
        if ({motor_sol, motor_sag, geri, mesgul} !== 4'b1100) begin
            errors++;
            $display("FAIL sag_after_turn: got %b required 1100", {motor_sol, motor_sag, geri, mesgul});
        end
        repeat (6) tick("sag_tail");
    endtask

    task automatic test_front();
        int n;
        int busy;
        int back;
        do_reset(1'b1);
        repeat (3) tick("fwd");
        on = 1'b1;
        n  = 0;
        while (mesgul !== 1'b1 && n < 30) begin
            tick("on_wait");
            n++;
        end
        checks++;
        if (mesgul !== 1'b1) begin
            errors++;
            $display("FAIL front_timeout: got mesgul=%b required 1", mesgul);
        end
        on   = 1'b0;
        busy = 0;
        back = 0;
        while (mesgul === 1'b1 && busy < 60) begin
            busy++;
            if (geri === 1'b1) back++;
            tick("front_man");
        end
        checks++;
        if (busy != GC + DC) begin
            errors++;
            $display("FAIL front_busy_len: got %0d required %0d", busy, GC + DC);
        end
        checks++;
        if (back != GC) begin
            errors++;
            $display("FAIL front_geri_len: got %0d required %0d", back, GC);
        end
        repeat (4) tick("front_tail");
    endtask

    task automatic test_glitch();
        do_reset(1'b1);
        repeat (3) tick("fwd");
        repeat (6) begin
            sol = 1'b1;
            repeat (N - 1) begin
                tick("glitch");
                checks++;
                if ({yon, motor_sol, motor_sag, mesgul} !== 5'b00110) begin
                    errors++;
                    $display("FAIL glitch_hold: got %b required 00110", {yon, motor_sol, motor_sag, mesgul});
                end
            end
            sol = 1'b0;
            tick("glitch_gap");
        end
    endtask

    task automatic test_abort();
        int n;
        do_reset(1'b1);
        repeat (3) tick("fwd");
        sol = 1'b1;
        n   = 0;
        while (mesgul !== 1'b1 && n < 30) begin
            tick("sol_wait");
            n++;
        end
        checks++;
        if ({motor_sol, motor_sag, geri, mesgul} !== 4'b1001) begin
            errors++;
            $display("FAIL abort_turn_start: got %b required 1001", {motor_sol, motor_sag, geri, mesgul});
        end
        tick("turn2");
        tick("turn3");
        calis = 1'b0;
        tick("abort");
        checks++;
        if ({motor_sol, motor_sag, geri, mesgul} !== 4'b0000) begin
            errors++;
            $display("FAIL abort_idle: got %b required 0000", {motor_sol, motor_sag, geri, mesgul});
        end
        calis = 1'b1;
        tick("resume");
        checks++;
        if ({motor_sol, motor_sag, geri, mesgul} !== 4'b1100) begin
            errors++;
            $display("FAIL resume_fwd: got %b required 1100", {motor_sol, motor_sag, geri, mesgul});
        end
        tick("return");
        checks++;
        if ({motor_sol, motor_sag, geri, mesgul} !== 4'b1001) begin
            errors++;
            $display("FAIL resume_turn: got %b required 1001", {motor_sol, motor_sag, geri, mesgul});
        end
        sol = 1'b0;
        repeat (12) tick("abort_tail");
    endtask

    task automatic test_reset_mid();
        int n;
        do_reset(1'b1);
        repeat (3) tick("fwd");
        on = 1'b1;
        n  = 0;
        while (geri !== 1'b1 && n < 30) begin
            tick("geri_wait");
            n++;
        end
        tick("geri2");
        rst = 1'b1;
        tick("mid_rst");
        checks++;
        if ({yon, motor_sol, motor_sag, geri, mesgul} !== 6'b0) begin
            errors++;
            $display("FAIL mid_reset: got %b required 000000", {yon, motor_sol, motor_sag, geri, mesgul});
        end
        rst = 1'b0;
        n   = 0;
        while (geri !== 1'b1 && n < 30) begin
            tick("refill");
            n++;
        end
        checks++;
        if (n != N + 1) begin
            errors++;
            $display("FAIL refill_latency: got %0d edges required %0d", n, N + 1);
        end
        on = 1'b0;
        repeat (20) tick("mid_tail");
    endtask

    task automatic test_random();
        int hold;
        do_reset(1'b1);
        for (int k = 0; k < 120; k++) begin
            sag   = 1'($urandom_range(0, 1));
            sol   = 1'($urandom_range(0, 1));
            on    = ($urandom_range(0, 3) == 0);
            calis = ($urandom_range(0, 9) != 0);
            rst   = ($urandom_range(0, 30) == 0);
            hold  = $urandom_range(1, 10);
            tick("rand");
            rst = 1'b0;
            repeat (hold - 1) tick("rand");
        end
    endtask

    initial begin
        rst   = 1'b1;
        calis = 1'b0;
        sag   = 1'b0;
        sol   = 1'b0;
        on    = 1'b0;
        test_reset();
        test_sag_turn();
        test_front();
        test_glitch();
        test_abort();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/yon_denetleyici.md
# yon_denetleyici

Sequential direction controller for the obstacle-avoiding robot. It debounces the three raw obstacle sensors (sag, sol, on) and computes the two-bit direction code {yon_solbit, yon_sagbit} from the filtered values. It then runs a timed manoeuvre state machine that drives the left and right wheel enables and the reverse line. It sits between the sensor pins and the motor driver and replaces direct combinational use of the direction encoder.

## Interface
- SUZGEC_N, 4, consecutive samples a raw sensor must disagree with its filtered value before the filtered value flips (≥2)
- DONUS_CYC, 8, cycles spent in a turn state (≥2)
- GERI_CYC, 6, cycles spent reversing (≥2)

Ports:
- clk  in  1  single system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- calis  in  1  run enable; 0 forces idle
- sag  in  1  raw right obstacle sensor, 1 = obstacle
- sol  in  1  raw left obstacle sensor, 1 = obstacle
- on  in  1  raw front obstacle sensor, 1 = obstacle
- yon  out  2  registered direction code {yon_solbit, yon_sagbit} of the filtered sensors
- motor_sol  out  1  left wheel enable
- motor_sag  out  1  right wheel enable
- geri  out  1  reverse command (both wheels backward)
- mesgul  out  1  1 while a timed manoeuvre (turn or reverse) is in progress

## Operation
- Filter: one filtered bit and one counter (width clog2(SUZGEC_N)+1) per sensor. Counter clears whenever raw equals filtered. The filtered bit takes the raw value on the SUZGEC_N-th consecutive edge where they differ, and the counter clears on that same edge.
- Code: yon_solbit = f_on | (f_sol & ~f_sag); yon_sagbit = f_on | f_sag. The code is registered into yon every cycle, one edge after the filtered bits change.
- States: BEKLE, ILERI, SOLA_DON, SAGA_DON, GERI.
- BEKLE: if calis=1, go to ILERI.
- ILERI: evaluates the code from the filtered bits directly, not from registered yon.
  - 00 → stay in ILERI.
  - 01 → SOLA_DON.
  - 10 → SAGA_DON.
  - 11 → GERI.
- Timed states:
  - On entry, the down-counter loads DONUS_CYC-1 (turns) or GERI_CYC-1 (GERI).
  - Sensors are ignored until the counter reaches 0.
  - At count 0: SOLA_DON and SAGA_DON go to ILERI. GERI goes to SOLA_DON and reloads DONUS_CYC-1.
- calis=0 in any state → BEKLE on the next edge. This aborts any manoeuvre and clears the counter. The filters keep running.
- Outputs are decoded from the state register (Moore):
  - BEKLE: motor_sol 0, motor_sag 0, geri 0, mesgul 0.
  - ILERI: motor_sol 1, motor_sag 1, geri 0, mesgul 0.
  - SOLA_DON: motor_sol 0, motor_sag 1, geri 0, mesgul 1.
  - SAGA_DON: motor_sol 1, motor_sag 0, geri 0, mesgul 1.
  - GERI: motor_sol 1, motor_sag 1, geri 1, mesgul 1.
- Never assert geri together with exactly one wheel enable.

## Timing
- Reset, applied on any edge with rst=1 including mid-manoeuvre:
  - State BEKLE; all filtered bits 0; all counters 0.
  - yon=00, motor_sol=0, motor_sag=0, geri=0, mesgul=0.
- Reset has priority over calis.
- Sensor to filtered: raw first sampled high at edge e1 and held → filtered high at edge e(SUZGEC_N).
- Filtered to state: the state changes at the next edge. Total raw-to-motor latency is SUZGEC_N+1 edges.
- A glitch shorter than SUZGEC_N samples never changes the filtered value or the state.
- Turn duration: exactly DONUS_CYC cycles with mesgul=1, then one or more ILERI cycles before any new decision.
- Front obstacle: GERI_CYC cycles in GERI, then DONUS_CYC cycles in SOLA_DON. mesgul stays 1 for GERI_CYC+DONUS_CYC consecutive cycles.
- Sensor changes during a timed state are filtered normally. They are acted on only at the first ILERI cycle after the manoeuvre.
- calis dropping and a manoeuvre expiring on the same edge: BEKLE wins.

## Test plan
All scenarios use the default parameters.
1. Reset with all sensors high, then rst=0 and calis=0 for 10 cycles → yon becomes 11 once the filters settle, state stays BEKLE, all motor outputs 0.
2. calis=1, sensors 0, then sag=1 held from edge e1 → filtered sag at e4, state SOLA_DON at e5 (motor_sol=0, motor_sag=1, mesgul=1) for exactly 8 cycles, then ILERI.
3. on=1 held → GERI for 6 cycles (geri=1, both wheels 1), then SOLA_DON for 8 cycles. mesgul is high for 14 consecutive cycles.
4. sol=1 pulses 3 cycles long, repeated with 1-cycle gaps → the filter never flips, state stays ILERI, yon=00 throughout.
5. sol=1 held → SAGA_DON. Pull calis=0 on the 3rd turn cycle → BEKLE at the next edge with all motor outputs 0. Set calis=1 again → ILERI, then immediately SAGA_DON because filtered sol is still 1.
6. Assert rst during GERI cycle 2 → all outputs 0 at that edge. After rst drops, the filters refill from 0, so re-entry to GERI takes 4+1 edges with on still held.
